dram_ctrl: RTL and testbench
============================

# dram_ctrl

Parametrised data-memory controller for the pipelined miniRV core. It replaces the bare combinational-read data memory with a request/response port. The port supports byte/halfword/word loads and stores with sign or zero extension, configurable read latency and misalignment/range error reporting. It sits between the core's MEM stage and an internal byte-lane word RAM; the core stalls on `req_ready`.

## Interface
- `ADDR_W`, 16: byte-address bits decoded; RAM holds 2**(ADDR_W-2) 32-bit words.
- `RD_LAT`, 1: load latency in cycles, legal range 1..4.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned`  in  1  load zero-extends when 1; ignored for stores and word loads.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected: misaligned, out of range, or size 3.

## Operation
- Acceptance: `req_valid & req_ready` at a rising edge. Exactly one request is outstanding at a time.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On accept, go to RESP if the request is a store, an error, or `RD_LAT`=1. Otherwise go to WAIT with the counter set to `RD_LAT`-2.
  - WAIT: `req_ready`=0. Decrement the counter; at 0, go to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=1. An accept here starts the next request with the same transitions as IDLE; otherwise return to IDLE.
- Error conditions:
  - `req_size`=3.
  - Half access with `req_addr[0]`=1.
  - Word access with `req_addr[1:0]`≠0.
  - `req_addr[31:ADDR_W]`≠0.
- An erroring request writes nothing and responds with `rsp_err`=1, `rsp_rdata`=0, always one cycle after acceptance.
- Stores:
  - The RAM updates at the accepting edge.
  - Byte store writes lane `addr[1:0]` with `wdata[7:0]`.
  - Half store writes lanes {`addr[1]`,1} and {`addr[1]`,0} with `wdata[15:0]`, little-endian.
  - Word store writes all four lanes.
  - Untouched lanes are preserved.
- Loads: select the lane(s) by `addr[1:0]` and size, then sign- or zero-extend to 32 bits. The offset and size are captured at acceptance and used at RESP.
- The RAM is not reset; its contents survive `rst_n`.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Store or error accepted at edge N: `rsp_valid` is high during cycle N+1. Back-to-back stores sustain one per cycle.
- Load accepted at edge N: `rsp_valid` is high during cycle N+`RD_LAT`. `req_ready` is low for cycles N+1..N+`RD_LAT`-1.
- A load issued in RESP immediately after a store to the same word returns the new data; the write commits before the read is sampled.
- `rsp_*` are registered outputs. `req_ready` is decoded from the state register, with no combinational path from `req_*`.
- Reset asserted mid-WAIT: the pending load is dropped and no response is produced. `req_ready`=1 on the first cycle after release.

## Structure
- Shared package `dram_pkg`:
  - Size encoding constants SZ_B, SZ_H, SZ_W.
  - FSM state enum.
  - Lane-select and extension functions.
- One sub-module, `dram_bank`: a 4-lane byte-enabled word RAM with a 1-cycle synchronous read port. The remaining `RD_LAT`-1 cycles are modelled by the controller's WAIT state.
- `dram_ctrl` holds the FSM, error decode, byte-enable generation, capture registers and load extension.

## Test plan
- `ADDR_W`=16, `RD_LAT`=1.
  - After reset, outputs equal the reset values.
  - `sw` 0x12345678 at 0x100 → `rsp_valid`, `rsp_err`=0 next cycle.
  - `lw` 0x100 → `rsp_rdata`=0x12345678 one cycle after accept.
- Byte lanes:
  - `sb` 0xAB at 0x101.
  - `lb` 0x101 → 0xFFFFFFAB.
  - `lbu` 0x101 → 0x000000AB.
  - `lw` 0x100 → 0x1234AB78.
- Halfword lanes:
  - `sh` 0x8001 at 0x102.
  - `lh` 0x102 → 0xFFFF8001.
  - `lhu` 0x102 → 0x00008001.
  - `lw` 0x100 → 0x8001AB78.
- Errors:
  - `lw` 0x102, `sh` 0x103, `sw` 0x00010000 and size 3 each → `rsp_err`=1, `rsp_rdata`=0.
  - Subsequent `lw` 0x100 still returns 0x8001AB78.
- `RD_LAT`=3:
  - Load accepted at edge N → `req_ready` low in N+1..N+2, `rsp_valid` in N+3.
  - Four stores issued on consecutive cycles → four responses on consecutive cycles.
- Assert `rst_n` low during WAIT for 2 cycles → no `rsp_valid` ever appears for that load. `req_ready`=1 after release, and `lw` 0x100 returns the prior contents.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the miniRV data-memory controller:
// access-size codes, FSM states, byte-lane and load-extension helpers.
package dram_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Byte enables for a store of size sz at byte offset off
    function automatic logic [3:0] lane_be(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes
    function automatic logic [31:0] lane_wdata(
        input logic [1:0]  sz,
        input logic [31:0] wd
    );
        logic [31:0] d;
        case (sz)
            SZ_B:    d = {4{wd[7:0]}};
            SZ_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Pick the addressed lane(s) and sign/zero extend
    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_W:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dram_bank.sv
// Byte-enabled 4-lane word RAM with a 1-cycle synchronous read port.
// Ports: clk, i_we/i_be/i_wdata write, i_re read strobe, i_addr word
// address, o_rdata read data (holds until the next read strobe).
module dram_bank #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_q;

    // Contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dram_ctrl.sv
// Request/response data-memory controller: one outstanding access,
// error decode, byte-lane stores and extended loads with RD_LAT latency.
// Ports: clk, rst_n, i_req_* request channel, o_req_ready, o_rsp_* response.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int WAW = ADDR_W - 2;
    localparam logic [1:0] CNT_INIT =
        (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t      r_state, w_next;
    logic [1:0]  r_cnt, w_cnt_next;
    logic        r_we, r_err, r_uns;
    logic [1:0]  r_off, r_size;

    logic        w_acc, w_err, w_direct;
    logic        w_mis, w_rng;
    logic [31:0] w_q;

    assign o_req_ready = (r_state != ST_WAIT);
    assign w_acc = i_req_valid & o_req_ready;

    assign w_mis = ((i_req_size == SZ_H) & i_req_addr[0])
                 | ((i_req_size == SZ_W) & (|i_req_addr[1:0]));
    assign w_rng = |(i_req_addr >> ADDR_W);
    assign w_err = (i_req_size == 2'd3) | w_mis | w_rng;

    // Stores, errors and single-cycle loads skip the WAIT state
    assign w_direct = i_req_we | w_err | (RD_LAT == 1);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_acc) begin
                    if (w_direct) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 2'd1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_uns   <= 1'b0;
            r_off   <= 2'd0;
            r_size  <= 2'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_acc) begin
                r_we   <= i_req_we;
                r_err  <= w_err;
                r_uns  <= i_req_unsigned;
                r_off  <= i_req_addr[1:0];
                r_size <= i_req_size;
            end
        end
    end

    dram_bank #(
        .AW(WAW)
    ) u_bank (
        .clk    (clk),
        .i_we   (w_acc & i_req_we & ~w_err),
        .i_be   (lane_be(i_req_size, i_req_addr[1:0])),
        .i_re   (w_acc & ~i_req_we & ~w_err),
        .i_addr (i_req_addr[ADDR_W-1:2]),
        .i_wdata(lane_wdata(i_req_size, i_req_wdata)),
        .o_rdata(w_q)
    );

    // Response is decoded purely from registered state and RAM output
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_err   = o_rsp_valid & r_err;
    assign o_rsp_rdata = (o_rsp_valid & ~r_we & ~r_err)
                       ? load_ext(w_q, r_off, r_size, r_uns)
                       : 32'd0;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_dram_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        req_valid, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        sel;

    logic        a_ready, a_vld, a_err;
    logic [31:0] a_rdata;
    logic        b_ready, b_vld, b_err;
    logic [31:0] b_rdata;

    logic        o_ready, o_vld, o_err;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    dram_ctrl #(.ADDR_W(16), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_a),
        .i_req_valid(req_valid & ~sel), .o_req_ready(a_ready),
        .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_size(req_size),
        .i_req_unsigned(req_unsigned),
        .o_rsp_valid(a_vld), .o_rsp_rdata(a_rdata), .o_rsp_err(a_err)
    );

    dram_ctrl #(.ADDR_W(16), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_b),
        .i_req_valid(req_valid & sel), .o_req_ready(b_ready),
        .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_size(req_size),
        .i_req_unsigned(req_unsigned),
        .o_rsp_valid(b_vld), .o_rsp_rdata(b_rdata), .o_rsp_err(b_err)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_vld   = sel ? b_vld   : a_vld;
    assign o_err   = sel ? b_err   : a_err;
    assign o_rdata = sel ? b_rdata : a_rdata;

    // Entered and left at a falling edge; lat counts cycles to rsp_valid
    task automatic txn(
        input  logic        we,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [1:0]  sz,
        input  logic        u,
        output logic [31:0] r,
        output logic        e,
        output int          l
    );
        req_we = we; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = u; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        l = 1;
        while (!o_vld && l < 10) begin
            @(negedge clk);
            l++;
        end
        r = o_rdata;
        e = o_err;
    endtask

    task automatic test_reset;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ready, a_vld, a_err, a_rdata} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL reset_a: rdy=%b vld=%b err=%b rd=%h req 1/0/0/0",
                     a_ready, a_vld, a_err, a_rdata);
        end
        checks++;
        if ({b_ready, b_vld, b_err, b_rdata} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL reset_b: rdy=%b vld=%b err=%b rd=%h req 1/0/0/0",
                     b_ready, b_vld, b_err, b_rdata);
        end
    endtask

    task automatic test_word;
        sel = 1'b0;
        txn(1, 32'h100, 32'h12345678, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 0 || er !== 0 || lat != 1) begin
            errors++;
            $display("FAIL sw: rd=%h err=%b lat=%0d req 0/0/1", rd, er, lat);
        end
        txn(0, 32'h100, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h12345678 || er !== 0 || lat != 1) begin
            errors++;
            $display("FAIL lw: rd=%h err=%b lat=%0d req 12345678/0/1",
                     rd, er, lat);
        end
    endtask

    task automatic test_byte;
        sel = 1'b0;
        txn(1, 32'h101, 32'h000000AB, 0, 0, rd, er, lat);
        txn(0, 32'h101, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFFAB || er !== 0 || lat != 1) begin
            errors++;
            $display("FAIL lb: rd=%h err=%b lat=%0d req FFFFFFAB", rd, er, lat);
        end
        txn(0, 32'h101, 0, 0, 1, rd, er, lat);
        checks++;
        if (rd !== 32'h000000AB || er !== 0) begin
            errors++;
            $display("FAIL lbu: rd=%h err=%b req 000000AB", rd, er);
        end
        txn(0, 32'h103, 0, 0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h00000012 || er !== 0) begin
            errors++;
            $display("FAIL lb3: rd=%h err=%b req 00000012", rd, er);
        end
        txn(0, 32'h100, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h1234AB78 || er !== 0) begin
            errors++;
            $display("FAIL lw_b: rd=%h err=%b req 1234AB78", rd, er);
        end
    endtask

    task automatic test_half;
        sel = 1'b0;
        txn(1, 32'h102, 32'hFFFF8001, 1, 0, rd, er, lat);
        txn(0, 32'h102, 0, 1, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF8001 || er !== 0) begin
            errors++;
            $display("FAIL lh: rd=%h err=%b req FFFF8001", rd, er);
        end
        txn(0, 32'h102, 0, 1, 1, rd, er, lat);
        checks++;
        if (rd !== 32'h00008001 || er !== 0) begin
            errors++;
            $display("FAIL lhu: rd=%h err=%b req 00008001", rd, er);
        end
        txn(0, 32'h100, 0, 1, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFAB78 || er !== 0) begin
            errors++;
            $display("FAIL lh0: rd=%h err=%b req FFFFAB78", rd, er);
        end
        txn(0, 32'h100, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h8001AB78 || er !== 0) begin
            errors++;
            $display("FAIL lw_h: rd=%h err=%b req 8001AB78", rd, er);
        end
    endtask

    task automatic test_errors;
        logic        we_t [4]   = '{0, 1, 1, 0};
        logic [31:0] ad_t [4]   = '{32'h102, 32'h103, 32'h10000, 32'h100};
        logic [1:0]  sz_t [4]   = '{2, 1, 2, 3};
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            txn(we_t[i], ad_t[i], 32'hDEADBEEF, sz_t[i], 0, rd, er, lat);
            checks++;
            if (rd !== 0 || er !== 1 || lat != 1) begin
                errors++;
                $display("FAIL err%0d: rd=%h err=%b lat=%0d req 0/1/1",
                         i, rd, er, lat);
            end
        end
        txn(0, 32'h100, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h8001AB78 || er !== 0) begin
            errors++;
            $display("FAIL lw_after_err: rd=%h err=%b req 8001AB78", rd, er);
        end
    endtask

    task automatic test_latency;
        sel = 1'b1;
        txn(1, 32'h100, 32'hCAFEF00D, 2, 0, rd, er, lat);
        checks++;
        if (er !== 0 || lat != 1) begin
            errors++;
            $display("FAIL sw_l3: err=%b lat=%0d req 0/1", er, lat);
        end
        req_we = 0; req_addr = 32'h100; req_size = 2; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (o_ready !== 0 || o_vld !== 0) begin
            errors++;
            $display("FAIL l3_n1: rdy=%b vld=%b req 0/0", o_ready, o_vld);
        end
        @(negedge clk);
        checks++;
        if (o_ready !== 0 || o_vld !== 0) begin
            errors++;
            $display("FAIL l3_n2: rdy=%b vld=%b req 0/0", o_ready, o_vld);
        end
        @(negedge clk);
        checks++;
        if (o_vld !== 1 || o_ready !== 1 || o_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL l3_n3: vld=%b rdy=%b rd=%h req 1/1/CAFEF00D",
                     o_vld, o_ready, o_rdata);
        end
        txn(0, 32'h101, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 0 || er !== 1 || lat != 1) begin
            errors++;
            $display("FAIL err_l3: rd=%h err=%b lat=%0d req 0/1/1",
                     rd, er, lat);
        end
    endtask

    task automatic test_back_to_back;
        sel = 1'b1;
        req_we = 1; req_size = 2; req_unsigned = 0;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h200 + 32'(4 * i);
            req_wdata = 32'hA0 + 32'(i);
            req_valid = 1;
            @(negedge clk);
            checks++;
            if (o_vld !== 1 || o_ready !== 1 || o_err !== 0) begin
                errors++;
                $display("FAIL b2b%0d: vld=%b rdy=%b err=%b req 1/1/0",
                         i, o_vld, o_ready, o_err);
            end
        end
        req_valid = 0;
        @(negedge clk);
        checks++;
        if (o_vld !== 0) begin
            errors++;
            $display("FAIL b2b_end: vld=%b req 0", o_vld);
        end
        txn(0, 32'h20C, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hA3 || er !== 0 || lat != 3) begin
            errors++;
            $display("FAIL b2b_rd: rd=%h err=%b lat=%0d req A3/0/3",
                     rd, er, lat);
        end
    endtask

    task automatic test_reset_wait;
        int seen;
        sel = 1'b1;
        req_we = 0; req_addr = 32'h100; req_size = 2; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        rst_b = 0;
        repeat (2) @(negedge clk);
        rst_b = 1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1) begin
            errors++;
            $display("FAIL rst_wait_rdy: rdy=%b req 1", o_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_vld === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_wait_rsp: pulses=%0d req 0", seen);
        end
        txn(0, 32'h100, 0, 2, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 0 || lat != 3) begin
            errors++;
            $display("FAIL rst_wait_lw: rd=%h err=%b lat=%0d req CAFEF00D/0/3",
                     rd, er, lat);
        end
    endtask

    initial begin
        rst_a = 0; rst_b = 0; sel = 0;
        req_valid = 0; req_we = 0; req_addr = 0;
        req_wdata = 0; req_size = 0; req_unsigned = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_latency();
        test_back_to_back();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
